lc_readout_arbiter: RTL and testbench
=====================================

# lc_readout_arbiter

Round-robin scheduler that shares one waveform readout engine among the per-channel `local_coinc` outputs of the local coincidence stage. A rising edge on any channel's coincidence flag latches a pending request. The block grants pending channels one at a time to the readout engine over a req/ack/done handshake, with a programmable timeout. It keeps saturating counters of dropped coincidences and readout timeouts for slow control.

## Interface
- `N_CHANNELS`, 24, number of coincidence channels.
- `P_CHAN_WIDTH`, 5, width of the channel index; must satisfy 2^P_CHAN_WIDTH >= N_CHANNELS.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  latch enable for new coincidence edges.
- `local_coinc`  in  N_CHANNELS  per-channel coincidence flags from the coincidence stage.
- `timeout_cycles`  in  16  readout timeout in clk cycles; 0 disables the timeout.
- `clr_cnt`  in  1  synchronous clear of both counters.
- `rdout_req`  out  1  readout request to the engine.
- `rdout_chan`  out  P_CHAN_WIDTH  channel being granted or read out.
- `rdout_ack`  in  1  engine accepted the request.
- `rdout_done`  in  1  engine finished the transfer.
- `pending`  out  N_CHANNELS  latched, not-yet-granted requests.
- `n_dropped`  out  16  saturating count of coincidence edges lost because that channel was already pending.
- `n_timeouts`  out  16  saturating count of aborted grants.

## Operation
- **Reset (async, `rst_n`=0):**
  - State goes to IDLE.
  - `rdout_req`=0, `rdout_chan`=0, `pending`=0, `n_dropped`=0, `n_timeouts`=0.
  - Edge-detect history register goes to 0, so a flag that is still high after reset counts as a new edge.
  - Round-robin pointer `last` goes to N_CHANNELS-1, so channel 0 has first priority.
- **Edge detection:**
  - `rise[i] = local_coinc[i] & ~prev[i]`; `prev` is registered every cycle, regardless of `en`.
  - With `en`=1, a rise with `pending[i]`=0 sets `pending[i]`.
  - With `en`=1, a rise with `pending[i]`=1 increments `n_dropped`; the request stays pending once.
  - With `en`=0, rises are ignored: nothing is latched and nothing is counted. Existing pending bits are still drained.
- **FSM states: IDLE, REQ, XFER.**
- **IDLE:**
  - Leaves only when `pending` != 0.
  - Selects the first set bit scanning `last+1, last+2, …` with wrap modulo N_CHANNELS.
  - On the transition edge: registers `rdout_chan`, sets `rdout_req`=1, clears that pending bit, updates `last`, zeroes the timer, and moves to REQ.
- **REQ:**
  - Holds `rdout_req`=1 and `rdout_chan` stable until `rdout_ack`=1 is sampled.
  - On ack: `rdout_req`=0 on that edge, the timer is zeroed, and the FSM moves to XFER.
- **XFER:**
  - `rdout_chan` stays stable.
  - On `rdout_done`=1 the FSM returns to IDLE. `rdout_done` is ignored in IDLE and REQ.
- **Timeout (REQ or XFER, `timeout_cycles`≠0):**
  - The timer increments every cycle in those states.
  - When timer == `timeout_cycles`-1 and no ack (REQ) or done (XFER) is seen that cycle, the FSM goes to IDLE.
  - On abort: `rdout_req`=0 and `n_timeouts` increments.
  - An ack or done arriving on that same cycle wins over the timeout.
- **Simultaneous set and clear:** a rise on the channel being granted on the same edge leaves `pending[i]`=1. This is a new request, not a drop.
- **Counters:** both saturate at 0xFFFF. `clr_cnt` has priority over an increment on the same cycle.
- **Re-trigger during readout:** a new rise on the channel currently in REQ or XFER sets its pending bit normally.

## Timing
- **Edge to request:** `local_coinc[i]` first sampled high at edge E.
  - `pending[i]`=1 after E.
  - `rdout_req`=1 after E+1 if IDLE; the pending bit clears at that same edge.
- **Ack to release:** ack sampled at edge A gives `rdout_req`=0 after A.
- **Back-to-back grants:** done sampled at edge D gives IDLE after D and the next `rdout_req` after D+1. The minimum gap between grants is 1 cycle with req low.
- **Timeout with T=`timeout_cycles`:** the abort edge is the T-th edge after entering REQ or XFER. `rdout_req` is high for exactly T cycles when there is no ack.
- **Outputs:** all are registered. `pending` and the counters update on the edge that causes them.

## Test plan
- **Single request:** reset, `en`=1, pulse `local_coinc[5]`, ack 3 cycles after req, done 10 cycles after ack.
  - `pending[5]` goes high 1 cycle after the pulse.
  - req high with `rdout_chan`=5 at the next cycle; req drops on ack.
  - FSM back in IDLE after done; `n_dropped`=`n_timeouts`=0.
- **Round-robin:** rises on channels 3, 7 and 20 in the same cycle, engine acks and finishes immediately.
  - Grants come in order 3, 7, 20.
  - Rises on 2 and 21 while 20 is busy are then granted 21 before 2.
- **Drop counting:** with channel 4 pending and the arbiter held in XFER, issue 3 more rises on channel 4.
  - `n_dropped`=3; channel 4 is granted once.
  - Repeat with `en`=0: no change to `pending` or the counters.
- **Timeout:** `timeout_cycles`=8, ack never asserted.
  - req high for exactly 8 cycles, then low; `n_timeouts`=1; the next pending channel is granted.
  - With `timeout_cycles`=0, req is held for 1000 cycles.
- **Boundary cases:**
  - Ack on the same cycle as the timeout: the FSM enters XFER and no timeout is counted.
  - A rise on the granted channel on the grant edge leaves pending=1 with no drop.
  - `clr_cnt` together with an increment leaves the counter at 0.
  - Drive 70000 drops: `n_dropped` holds at 0xFFFF.
- **Reset mid-XFER:** assert `rst_n`=0 asynchronously during XFER while `local_coinc[9]` is held high.
  - All outputs go to 0 immediately.
  - After release, `pending[9]` sets on the first edge and channel 9 is granted.

Source files
------------

// File: rtl/lc_readout_arbiter.sv
// lc_readout_arbiter: round-robin scheduler that grants latched coincidence
// edges to a shared waveform readout engine over a req/ack/done handshake.
module lc_readout_arbiter #(
    parameter int N_CHANNELS   = 24,
    parameter int P_CHAN_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [N_CHANNELS-1:0]   local_coinc,
    input  logic [15:0]             timeout_cycles,
    input  logic                    clr_cnt,
    output logic                    rdout_req,
    output logic [P_CHAN_WIDTH-1:0] rdout_chan,
    input  logic                    rdout_ack,
    input  logic                    rdout_done,
    output logic [N_CHANNELS-1:0]   pending,
    output logic [15:0]             n_dropped,
    output logic [15:0]             n_timeouts
);
    localparam int CNT_W = $clog2(N_CHANNELS + 1);

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;
    state_t state, state_nxt;

    logic [N_CHANNELS-1:0]   prev, rise, grant_mask, drop_mask, pending_nxt;
    logic [P_CHAN_WIDTH-1:0] last, sel_chan;
    logic                    sel_found, grant, abort, timer_hit;
    logic [15:0]             timer, timer_nxt;
    logic [CNT_W-1:0]        drop_cnt;
    logic [16:0]             drop_sum;
    int unsigned             scan_idx;

    // Scan begins just after the last granted channel and wraps modulo N.
    always_comb begin
        sel_found = 1'b0;
        sel_chan  = '0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < N_CHANNELS; k++) begin
            scan_idx = 32'(last) + 32'd1 + k;
            if (scan_idx >= N_CHANNELS)
                scan_idx = scan_idx - 32'(N_CHANNELS);
            if (!sel_found && pending[scan_idx[P_CHAN_WIDTH-1:0]]) begin
                sel_found = 1'b1;
                sel_chan  = scan_idx[P_CHAN_WIDTH-1:0];
            end
        end
    end

    assign timer_hit = (timeout_cycles != 16'd0) && (timer == timeout_cycles - 16'd1);

    // Ack/done take precedence over a timeout expiring on the same cycle.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        abort     = 1'b0;
        timer_nxt = timer + 16'd1;
        case (state)
            IDLE: begin
                timer_nxt = '0;
                if (sel_found) begin
                    grant     = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (rdout_ack) begin
                    state_nxt = XFER;
                    timer_nxt = '0;
                end else if (timer_hit) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end
            end
            XFER: begin
                if (rdout_done) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else if (timer_hit) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A rise on the channel being granted re-arms it rather than counting a drop.
    always_comb begin
        rise        = local_coinc & ~prev;
        grant_mask  = grant ? (N_CHANNELS'(1) << sel_chan) : '0;
        drop_mask   = en ? (rise & pending & ~grant_mask) : '0;
        pending_nxt = (pending & ~grant_mask) | (en ? rise : '0);
        drop_cnt    = CNT_W'($countones(drop_mask));
        drop_sum    = {1'b0, n_dropped} + 17'(drop_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            prev       <= '0;
            pending    <= '0;
            last       <= P_CHAN_WIDTH'(N_CHANNELS - 1);
            rdout_req  <= 1'b0;
            rdout_chan <= '0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            prev    <= local_coinc;
            pending <= pending_nxt;
            if (grant) begin
                rdout_req  <= 1'b1;
                rdout_chan <= sel_chan;
                last       <= sel_chan;
            end else if (state == REQ && state_nxt != REQ) begin
                rdout_req <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_dropped  <= '0;
            n_timeouts <= '0;
        end else begin
            if (clr_cnt)
                n_dropped <= '0;
            else if (|drop_mask)
                n_dropped <= drop_sum[16] ? '1 : drop_sum[15:0];

            if (clr_cnt)
                n_timeouts <= '0;
            else if (abort && n_timeouts != '1)
                n_timeouts <= n_timeouts + 16'd1;
        end
    end
endmodule

// File: tb/tb_lc_readout_arbiter.sv
// Directed testbench for lc_readout_arbiter with hand-computed expectations.
module tb_lc_readout_arbiter;
    localparam int N  = 24;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [N-1:0]  local_coinc = '0;
    logic [15:0]   timeout_cycles = '0;
    logic          clr_cnt = 1'b0;
    logic          rdout_req;
    logic [CW-1:0] rdout_chan;
    logic          rdout_ack = 1'b0;
    logic          rdout_done = 1'b0;
    logic [N-1:0]  pending;
    logic [15:0]   n_dropped;
    logic [15:0]   n_timeouts;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    lc_readout_arbiter #(.N_CHANNELS(N), .P_CHAN_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .local_coinc(local_coinc),
        .timeout_cycles(timeout_cycles), .clr_cnt(clr_cnt),
        .rdout_req(rdout_req), .rdout_chan(rdout_chan),
        .rdout_ack(rdout_ack), .rdout_done(rdout_done),
        .pending(pending), .n_dropped(n_dropped), .n_timeouts(n_timeouts)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [N-1:0] mask);
        local_coinc = mask;
        tick();
        local_coinc = '0;
        tick();
    endtask

    task automatic wait_req(input string tag);
        int unsigned n = 0;
        while (!rdout_req && n < 50) begin
            tick();
            n++;
        end
        check(tag, 32'(rdout_req), 1);
    endtask

    task automatic ack_done();
        rdout_ack = 1'b1;
        tick();
        rdout_ack  = 1'b0;
        rdout_done = 1'b1;
        tick();
        rdout_done = 1'b0;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        local_coinc = '0;
        rdout_ack   = 1'b0;
        rdout_done  = 1'b0;
        clr_cnt     = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int unsigned n;

        // Reset state
        tick();
        check("rst_req", 32'(rdout_req), 0);
        check("rst_chan", 32'(rdout_chan), 0);
        check("rst_pend", 32'(pending), 0);
        check("rst_ndrop", 32'(n_dropped), 0);
        check("rst_nto", 32'(n_timeouts), 0);
        tick();
        rst_n = 1'b1;
        en    = 1'b1;

        // Single request on channel 5
        local_coinc[5] = 1'b1;
        tick();
        local_coinc = '0;
        check("t1_pend", 32'(pending), 32'(24'h000020));
        check("t1_req_lo", 32'(rdout_req), 0);
        tick();
        check("t1_req_hi", 32'(rdout_req), 1);
        check("t1_chan", 32'(rdout_chan), 5);
        check("t1_pend_clr", 32'(pending), 0);
        tick();
        tick();
        check("t1_req_hold", 32'(rdout_req), 1);
        rdout_ack = 1'b1;
        tick();
        rdout_ack = 1'b0;
        check("t1_req_drop", 32'(rdout_req), 0);
        check("t1_chan_hold", 32'(rdout_chan), 5);
        repeat (9) tick();
        rdout_done = 1'b1;
        tick();
        rdout_done = 1'b0;
        local_coinc[6] = 1'b1;
        tick();
        local_coinc = '0;
        tick();
        check("t1_idle_regrant", 32'(rdout_req), 1);
        check("t1_idle_chan", 32'(rdout_chan), 6);
        ack_done();
        check("t1_ndrop", 32'(n_dropped), 0);
        check("t1_nto", 32'(n_timeouts), 0);

        // Round-robin ordering
        do_reset();
        local_coinc = (N'(1) << 3) | (N'(1) << 7) | (N'(1) << 20);
        tick();
        local_coinc = '0;
        check("t2_pend", 32'(pending), 32'(24'h100088));
        wait_req("t2_req3");
        check("t2_chan3", 32'(rdout_chan), 3);
        ack_done();
        wait_req("t2_req7");
        check("t2_chan7", 32'(rdout_chan), 7);
        ack_done();
        wait_req("t2_req20");
        check("t2_chan20", 32'(rdout_chan), 20);
        rdout_ack = 1'b1;
        tick();
        rdout_ack   = 1'b0;
        local_coinc = (N'(1) << 2) | (N'(1) << 21);
        tick();
        local_coinc = '0;
        check("t2_pend_busy", 32'(pending), 32'(24'h200004));
        rdout_done = 1'b1;
        tick();
        rdout_done = 1'b0;
        wait_req("t2_req21");
        check("t2_chan21", 32'(rdout_chan), 21);
        ack_done();
        wait_req("t2_req2");
        check("t2_chan2", 32'(rdout_chan), 2);
        ack_done();

        // Drop counting while busy, then with en low
        do_reset();
        local_coinc[0] = 1'b1;
        tick();
        local_coinc = '0;
        wait_req("t3_req0");
        rdout_ack = 1'b1;
        tick();
        rdout_ack = 1'b0;
        pulse(N'(1) << 4);
        repeat (3) pulse(N'(1) << 4);
        check("t3_ndrop3", 32'(n_dropped), 3);
        check("t3_pend4", 32'(pending), 32'(24'h000010));
        en = 1'b0;
        repeat (3) pulse(N'(1) << 4);
        pulse(N'(1) << 6);
        check("t3_en0_ndrop", 32'(n_dropped), 3);
        check("t3_en0_pend", 32'(pending), 32'(24'h000010));
        en = 1'b1;
        rdout_done = 1'b1;
        tick();
        rdout_done = 1'b0;
        wait_req("t3_req4");
        check("t3_chan4", 32'(rdout_chan), 4);
        check("t3_pend_empty", 32'(pending), 0);
        ack_done();
        repeat (5) tick();
        check("t3_once", 32'(rdout_req), 0);

        // Rise on the channel being granted, on the grant edge
        do_reset();
        local_coinc[0] = 1'b1;
        tick();
        local_coinc = '0;
        wait_req("t5_req0");
        rdout_ack = 1'b1;
        tick();
        rdout_ack = 1'b0;
        pulse(N'(1) << 8);
        rdout_done = 1'b1;
        tick();
        rdout_done     = 1'b0;
        local_coinc[8] = 1'b1;
        tick();
        local_coinc = '0;
        check("t5_req", 32'(rdout_req), 1);
        check("t5_chan", 32'(rdout_chan), 8);
        check("t5_pend_kept", 32'(pending), 32'(24'h000100));
        check("t5_no_drop", 32'(n_dropped), 0);
        ack_done();
        wait_req("t5_req8b");
        check("t5_chan8b", 32'(rdout_chan), 8);
        check("t5_pend_empty", 32'(pending), 0);
        ack_done();

        // Timeouts
        do_reset();
        timeout_cycles = 16'd8;
        local_coinc = (N'(1) << 1) | (N'(1) << 10);
        tick();
        local_coinc = '0;
        wait_req("t4_req1");
        n = 0;
        while (rdout_req && n < 20) begin
            n++;
            tick();
        end
        check("t4_req_len", n, 8);
        check("t4_nto1", 32'(n_timeouts), 1);
        wait_req("t4_req10");
        check("t4_chan10", 32'(rdout_chan), 10);
        repeat (7) tick();
        check("t4_pre_edge", 32'(rdout_req), 1);
        rdout_ack = 1'b1;
        tick();
        rdout_ack = 1'b0;
        check("t4_ack_wins", 32'(rdout_req), 0);
        check("t4_ack_nto", 32'(n_timeouts), 1);
        rdout_done = 1'b1;
        tick();
        rdout_done = 1'b0;
        check("t4_done_nto", 32'(n_timeouts), 1);
        local_coinc[2] = 1'b1;
        tick();
        local_coinc = '0;
        wait_req("t4_req2");
        repeat (7) tick();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("t4_clr_req", 32'(rdout_req), 0);
        check("t4_clr_nto", 32'(n_timeouts), 0);
        local_coinc[11] = 1'b1;
        tick();
        local_coinc = '0;
        wait_req("t4_req11");
        rdout_ack = 1'b1;
        tick();
        rdout_ack = 1'b0;
        repeat (7) tick();
        check("t4_xfer_pre", 32'(n_timeouts), 0);
        tick();
        check("t4_xfer_abort", 32'(n_timeouts), 1);
        timeout_cycles = 16'd0;
        local_coinc[3] = 1'b1;
        tick();
        local_coinc = '0;
        wait_req("t4_req3");
        n = 0;
        repeat (1000) begin
            if (rdout_req) n++;
            tick();
        end
        check("t4_no_timeout", n, 1000);
        check("t4_no_timeout_nto", 32'(n_timeouts), 1);
        ack_done();

        // Drop counter saturation and clear priority
        do_reset();
        local_coinc[0] = 1'b1;
        tick();
        local_coinc = '0;
        wait_req("t6_req0");
        rdout_ack = 1'b1;
        tick();
        rdout_ack = 1'b0;
        pulse(24'hFFFFFE);
        check("t6_pend", 32'(pending), 32'(24'hFFFFFE));
        pulse(24'hFFFFFE);
        check("t6_ndrop23", 32'(n_dropped), 23);
        repeat (3100) pulse(24'hFFFFFE);
        check("t6_sat", 32'(n_dropped), 32'h0000FFFF);
        local_coinc = 24'hFFFFFE;
        clr_cnt     = 1'b1;
        tick();
        local_coinc = '0;
        clr_cnt     = 1'b0;
        check("t6_clr_wins", 32'(n_dropped), 0);

        // Asynchronous reset during XFER with channel 9 held high
        do_reset();
        local_coinc[9] = 1'b1;
        wait_req("t7_req9");
        check("t7_chan9", 32'(rdout_chan), 9);
        rdout_ack = 1'b1;
        tick();
        rdout_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t7_async_req", 32'(rdout_req), 0);
        check("t7_async_chan", 32'(rdout_chan), 0);
        check("t7_async_pend", 32'(pending), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t7_pend9", 32'(pending), 32'(24'h000200));
        tick();
        check("t7_regrant", 32'(rdout_req), 1);
        check("t7_regrant_chan", 32'(rdout_chan), 9);
        local_coinc = '0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
